mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: MEM_LATENCY, default 4, cycles from request acceptance to completion broadcast; legal range 1..15.
REQ-002 Parameter: NUM_MEM_TAGS, default 15, number of transaction tags; legal range 1..15; tags are 1..NUM_MEM_TAGS, and tag 0 means "none".
REQ-003 Parameter: MEM_WORDS, default 8192, number of 64-bit memory words.
REQ-004 clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 proc2mem_command  input  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; the value 3 is treated as BUS_NONE.
REQ-007 proc2mem_addr  input  XLEN  byte address; word index is addr[3+:clog2(MEM_WORDS)], and addr[2:0] is ignored.
REQ-008 proc2mem_data  input  64  store data.
REQ-009 mem2proc_response  output  4  combinational accept tag for the current-cycle request; 0 means rejected.
REQ-010 mem2proc_data  output  64  registered load data, valid while mem2proc_tag is nonzero.
REQ-011 mem2proc_tag  output  4  registered completion tag; 0 means no completion this cycle.

Function
REQ-012 Storage: MEM_WORDS x 64-bit array, not cleared by reset; contents are loaded only by init file or bench backdoor.
REQ-013 Slot table: NUM_MEM_TAGS entries, each holding {valid, is_load, data, countdown}; entry i owns tag i+1.
REQ-014 Acceptance conditions: command is LOAD or STORE, addr < MEM_WORDS*8, reset is low, and at least one entry is free.
REQ-015 When accepted: mem2proc_response = lowest free tag in the same cycle (combinational); otherwise mem2proc_response = 0.
REQ-016 An entry completing in the current cycle is not free for that cycle's acceptance.
REQ-017 Load accept edge: entry marked valid, is_load=1, countdown=MEM_LATENCY, data = memory word snapshot at that edge.
REQ-018 Store accept edge: memory word written with proc2mem_data; entry marked valid, is_load=0, countdown=MEM_LATENCY.
REQ-019 A store is visible to any load accepted in a later cycle.
REQ-020 Each edge decrements the countdown of every valid entry that is nonzero.
REQ-021 Completion cycle: an entry with countdown 1 at an edge drives its outputs during the following cycle (cycle T+MEM_LATENCY for acceptance in cycle T).
- Load entry: mem2proc_tag = tag, mem2proc_data = stored data.
- Store entry: mem2proc_tag = 0, mem2proc_data = 0.
- In both cases the entry is freed at the edge ending the completion cycle.
REQ-022 At most one completion per cycle, guaranteed by one acceptance per cycle and fixed latency; simultaneous countdown expiry is illegal, and the design shall assert on it.
REQ-023 Outputs mem2proc_tag and mem2proc_data are 0 in any cycle with no load completion.
REQ-024 Full condition: with all entries valid, every request is rejected (response 0) and no state changes; the requester retries.
REQ-025 A rejected request has no side effect: no memory write and no entry allocated.
REQ-026 Tag wrap: allocation is always lowest-free, so tags are reused immediately after release with no round-robin.

Reset
REQ-027 On an edge with reset high, all entries clear, mem2proc_tag and mem2proc_data become 0, and mem2proc_response is forced to 0.
REQ-028 Outstanding transactions at reset are dropped and never complete; memory contents are unchanged.
REQ-029 The first acceptance after reset deasserts returns tag 1.

Verification
REQ-030 Backdoor word 5 = 0xDEAD_BEEF_0123_4567; LOAD addr 0x28 in cycle 0 -> response 1 in cycle 0; tag 1 with data 0xDEAD_BEEF_0123_4567 in cycle 4; tag 0 in cycles 1-3 and 5.
REQ-031 STORE addr 0x10 data 0x55 in cycle 0, LOAD addr 0x10 in cycle 1 -> responses 1 then 2; mem2proc_tag stays 0 in cycle 4; tag 2 with data 0x55 in cycle 5.
REQ-032 NUM_MEM_TAGS=2, MEM_LATENCY=4, LOADs in cycles 0-3 -> responses 1, 2, 0, 0; cycle 4 (tag 1 completing) response 0; cycle 5 LOAD -> response 1.
REQ-033 LOAD addr = MEM_WORDS*8 -> response 0, no completion ever; command 3 -> response 0.
REQ-034 LOAD accepted in cycle 0, reset asserted in cycle 2 -> mem2proc_tag 0 through cycle 6; LOAD in cycle 3 after reset deasserts -> response 1, completion in cycle 7.
REQ-035 Back-to-back LOADs in cycles 0-9 with default parameters -> responses cycle through tags 1-5, then tag 1 reused from cycle 5 onward (tag 1 frees at edge ending cycle 4); completions in cycles 4-13 each carry the correct word.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency tagged memory responder: accepts one load/store per cycle,
// hands back the lowest free tag, and broadcasts load completions MEM_LATENCY cycles later.
module mem_responder #(
    parameter int MEM_LATENCY  = 4,
    parameter int NUM_MEM_TAGS = 15,
    parameter int MEM_WORDS    = 8192,
    parameter int XLEN         = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      proc2mem_command,
    input  logic [XLEN-1:0] proc2mem_addr,
    input  logic [63:0]     proc2mem_data,
    output logic [3:0]      mem2proc_response,
    output logic [63:0]     mem2proc_data,
    output logic [3:0]      mem2proc_tag
);

    localparam logic [1:0]      BUS_LOAD   = 2'd1;
    localparam logic [1:0]      BUS_STORE  = 2'd2;
    localparam int              IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]      LAT        = 4'(MEM_LATENCY);
    localparam longint unsigned ADDR_LIMIT = 64'(MEM_WORDS) * 64'd8;

    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic [63:0] data;
        logic [3:0]  count;
    } slot_t;

    logic [63:0]      mem [MEM_WORDS];
    slot_t            slots      [NUM_MEM_TAGS];
    slot_t            slots_next [NUM_MEM_TAGS];

    logic [IDX_W-1:0] word_idx;
    logic             cmd_ok;
    logic             addr_ok;
    logic             have_free;
    logic [3:0]       free_idx;
    logic             accept;
    logic             is_load_req;
    logic [3:0]       tag_next;
    logic [63:0]      data_next;
    logic [4:0]       n_expiring;

    assign word_idx    = proc2mem_addr[3 +: IDX_W];
    assign is_load_req = (proc2mem_command == BUS_LOAD);
    assign cmd_ok      = is_load_req || (proc2mem_command == BUS_STORE);
    assign addr_ok     = (64'(proc2mem_addr) < ADDR_LIMIT);

    // Completing entries are still valid, so they are never picked as free.
    always_comb begin
        have_free = 1'b0;
        free_idx  = 4'd0;
        for (int i = NUM_MEM_TAGS - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                have_free = 1'b1;
                free_idx  = 4'(i);
            end
        end
    end

    assign accept            = cmd_ok && addr_ok && !reset && have_free;
    assign mem2proc_response = accept ? (free_idx + 4'd1) : 4'd0;

    always_comb begin
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            slots_next[i] = slots[i];
            if (slots[i].valid) begin
                if (slots[i].count == 4'd1) begin
                    slots_next[i] = '0;
                end else if (slots[i].count != 4'd0) begin
                    slots_next[i].count = slots[i].count - 4'd1;
                end
            end
            if (accept && (free_idx == 4'(i))) begin
                slots_next[i].valid   = 1'b1;
                slots_next[i].is_load = is_load_req;
                slots_next[i].data    = is_load_req ? mem[word_idx] : 64'd0;
                slots_next[i].count   = LAT;
            end
        end
    end

    // An entry whose count reaches 1 after this edge owns the next cycle's broadcast.
    always_comb begin
        tag_next  = 4'd0;
        data_next = 64'd0;
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            if (slots_next[i].valid && slots_next[i].is_load && (slots_next[i].count == 4'd1)) begin
                tag_next  = 4'(i + 1);
                data_next = slots_next[i].data;
            end
        end
    end

    always_comb begin
        n_expiring = 5'd0;
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            if (slots[i].valid && (slots[i].count == 4'd1)) begin
                n_expiring = n_expiring + 5'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MEM_TAGS; i++) begin
                slots[i] <= '0;
            end
            mem2proc_tag  <= 4'd0;
            mem2proc_data <= 64'd0;
        end else begin
            for (int i = 0; i < NUM_MEM_TAGS; i++) begin
                slots[i] <= slots_next[i];
            end
            mem2proc_tag  <= tag_next;
            mem2proc_data <= data_next;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (accept && !is_load_req) begin
            mem[word_idx] <= proc2mem_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            single_expiry: assert (n_expiring <= 5'd1);
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a cycle table on a default-parameter instance,
// plus a hand sequence on small instances for the full and single-cycle-latency cases.
module tb_mem_responder;

    localparam logic [1:0] NO = 2'd0;
    localparam logic [1:0] LD = 2'd1;
    localparam logic [1:0] ST = 2'd2;
    localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  a_cmd = NO;
    logic [31:0] a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic [3:0]  a_resp, a_tag;
    logic [63:0] a_rdata;

    logic [1:0]  b_cmd = NO;
    logic [31:0] b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic [3:0]  b2_resp, b2_tag, b3_resp, b3_tag;
    logic [63:0] b2_rdata, b3_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_responder dut (
        .clock(clock), .reset(reset),
        .proc2mem_command(a_cmd), .proc2mem_addr(a_addr), .proc2mem_data(a_wdata),
        .mem2proc_response(a_resp), .mem2proc_data(a_rdata), .mem2proc_tag(a_tag)
    );

    mem_responder #(.MEM_LATENCY(4), .NUM_MEM_TAGS(2)) dut2 (
        .clock(clock), .reset(reset),
        .proc2mem_command(b_cmd), .proc2mem_addr(b_addr), .proc2mem_data(b_wdata),
        .mem2proc_response(b2_resp), .mem2proc_data(b2_rdata), .mem2proc_tag(b2_tag)
    );

    mem_responder #(.MEM_LATENCY(1), .NUM_MEM_TAGS(1)) dut3 (
        .clock(clock), .reset(reset),
        .proc2mem_command(b_cmd), .proc2mem_addr(b_addr), .proc2mem_data(b_wdata),
        .mem2proc_response(b3_resp), .mem2proc_data(b3_rdata), .mem2proc_tag(b3_tag)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  resp;
        logic [3:0]  tag;
        logic [63:0] rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic rst, input logic [1:0] cmd, input logic [31:0] addr,
                              input logic [63:0] data, input logic [3:0] resp,
                              input logic [3:0] tag, input logic [63:0] rdata);
        vec_t r;
        r.rst = rst; r.cmd = cmd; r.addr = addr; r.data = data;
        r.resp = resp; r.tag = tag; r.rdata = rdata;
        vecs.push_back(r);
    endfunction

    function automatic logic [63:0] word_val(input int k);
        return {32'hC0DE_0000 + 32'(k), 32'h0F0F_0000 + 32'(k * 7)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bcyc(input int c, input logic [1:0] cmd, input logic [31:0] addr,
                        input logic [63:0] wd,
                        input logic [3:0] r2, input logic [3:0] t2, input logic [63:0] d2,
                        input logic [3:0] r3, input logic [3:0] t3, input logic [63:0] d3);
        b_cmd = cmd; b_addr = addr; b_wdata = wd;
        @(negedge clock);
        chk($sformatf("small c%0d resp2", c), 64'(b2_resp), 64'(r2));
        chk($sformatf("small c%0d tag2", c), 64'(b2_tag), 64'(t2));
        chk($sformatf("small c%0d data2", c), b2_rdata, d2);
        chk($sformatf("lat1 c%0d resp3", c), 64'(b3_resp), 64'(r3));
        chk($sformatf("lat1 c%0d tag3", c), 64'(b3_tag), 64'(t3));
        chk($sformatf("lat1 c%0d data3", c), b3_rdata, d3);
        @(posedge clock);
        #1;
    endtask

    initial begin
        dut.mem[5]  = DB;
        dut2.mem[8] = 64'h1234;
        dut3.mem[8] = 64'h1234;
        for (int k = 0; k < 10; k++) dut.mem[32 + k] = word_val(k);

        // reset cycles: request ignored
        v(1, LD, 'h28, 0, 0, 0, 0);
        v(1, LD, 'h28, 0, 0, 0, 0);
        // single load of backdoor word
        v(0, LD, 'h28, 0, 1, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 1, DB);
        v(0, NO, 0, 0, 0, 0, 0);
        // store then load of same word
        v(0, ST, 'h10, 'h55, 1, 0, 0);
        v(0, LD, 'h10, 0, 2, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 2, 'h55);
        v(0, NO, 0, 0, 0, 0, 0);
        // out of range, command 3, low address bits ignored
        v(0, LD, 'h10000, 0, 0, 0, 0);
        v(0, 2'd3, 'h28, 0, 0, 0, 0);
        v(0, ST, 'h10000, 'hBAD, 0, 0, 0);
        v(0, LD, 'h2F, 0, 1, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 1, DB);
        v(0, NO, 0, 0, 0, 0, 0);
        // reset drops an outstanding load, memory survives
        v(0, LD, 'h28, 0, 1, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(1, LD, 'h28, 0, 0, 0, 0);
        v(0, LD, 'h10, 0, 1, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 0, 0);
        v(0, NO, 0, 0, 0, 1, 'h55);
        v(0, NO, 0, 0, 0, 0, 0);
        // back-to-back loads, tags wrap 1..5 twice
        for (int k = 0; k < 14; k++) begin
            v(0, (k < 10) ? LD : NO, 32'h100 + 32'(8 * k), 0,
              (k < 10) ? 4'((k % 5) + 1) : 4'd0,
              (k >= 4) ? 4'(((k - 4) % 5) + 1) : 4'd0,
              (k >= 4) ? word_val(k - 4) : 64'd0);
        end
        v(0, NO, 0, 0, 0, 0, 0);

        @(posedge clock);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; a_cmd = vecs[i].cmd; a_addr = vecs[i].addr; a_wdata = vecs[i].data;
            @(negedge clock);
            chk($sformatf("row%0d resp", i), 64'(a_resp), 64'(vecs[i].resp));
            chk($sformatf("row%0d tag", i), 64'(a_tag), 64'(vecs[i].tag));
            chk($sformatf("row%0d data", i), a_rdata, vecs[i].rdata);
            @(posedge clock);
            #1;
        end
        reset = 1'b0; a_cmd = NO;

        // two-tag instance fills up; single-tag latency-1 instance sees same stimulus
        bcyc(0,  LD, 'h40, 0,      1, 0, 0,      1, 0, 0);
        bcyc(1,  LD, 'h40, 0,      2, 0, 0,      0, 1, 'h1234);
        bcyc(2,  ST, 'h40, 'hFFFF, 0, 0, 0,      1, 0, 0);
        bcyc(3,  LD, 'h40, 0,      0, 0, 0,      0, 0, 0);
        bcyc(4,  LD, 'h40, 0,      0, 1, 'h1234, 1, 0, 0);
        bcyc(5,  LD, 'h40, 0,      1, 2, 'h1234, 0, 1, 'hFFFF);
        bcyc(6,  NO, 0, 0,         0, 0, 0,      0, 0, 0);
        bcyc(7,  NO, 0, 0,         0, 0, 0,      0, 0, 0);
        bcyc(8,  NO, 0, 0,         0, 0, 0,      0, 0, 0);
        bcyc(9,  NO, 0, 0,         0, 1, 'h1234, 0, 0, 0);
        bcyc(10, NO, 0, 0,         0, 0, 0,      0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
